// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: ALU operation codes, R-type funct and
// I-type opcode values, alu_op / md_op encodings and the mul/div sequencer state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] AOP_MEM    = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_RTYPE  = 2'b10;
  localparam logic [1:0] AOP_ITYPE  = 2'b11;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational (alu_op, funct) decode into ALU code, shift-source select, illegal flag
// and mul/div request. DIV/DIVU are recognised only when ALU_CTRL_DIV_EN is defined.
module alu_funct_decode (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       shamt_sel,
  output logic       illegal,
  output logic       is_md,
  output logic [1:0] md_op
);
  import alu_ctrl_pkg::*;

  // Unsupported encodings fall through to the ADD/illegal defaults.
  always_comb begin
    code      = ALU_ADD;
    shamt_sel = 1'b0;
    illegal   = 1'b0;
    is_md     = 1'b0;
    md_op     = MD_MULT;
    case (alu_op)
      AOP_MEM:    code = ALU_ADD;
      AOP_BRANCH: code = ALU_SUB;
      AOP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: code = ALU_ADD;
          FN_SUB, FN_SUBU: code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          FN_SLTU: code = ALU_SLTU;
          FN_SLL: begin code = ALU_SLL; shamt_sel = 1'b1; end
          FN_SRL: begin code = ALU_SRL; shamt_sel = 1'b1; end
          FN_SRA: begin code = ALU_SRA; shamt_sel = 1'b1; end
          FN_MULT:  begin is_md = 1'b1; md_op = MD_MULT;  end
          FN_MULTU: begin is_md = 1'b1; md_op = MD_MULTU; end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV:   begin is_md = 1'b1; md_op = MD_DIV;  end
          FN_DIVU:  begin is_md = 1'b1; md_op = MD_DIVU; end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        case (funct)
          OP_ADDI, OP_ADDIU: code = ALU_ADD;
          OP_SLTI:  code = ALU_SLT;
          OP_SLTIU: code = ALU_SLTU;
          OP_ANDI:  code = ALU_AND;
          OP_ORI:   code = ALU_OR;
          OP_XORI:  code = ALU_XOR;
          OP_LUI:   code = ALU_LUI;
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control unit with mul/div busy/ready sequencing and HI/LO write strobe.
// Define ALU_CTRL_DIV_EN to sequence DIV/DIVU for DIV_CYCLES; otherwise they are illegal.
module alu_control_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic              ready_out,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              ctrl_valid,
  output logic              shamt_sel,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              busy,
  output logic              hilo_we
);
  import alu_ctrl_pkg::*;

`ifdef ALU_CTRL_DIV_EN
  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
`else
  localparam int CNT_MAX = MUL_CYCLES;
  logic unused_div;
  assign unused_div = ^DIV_CYCLES;
`endif
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [3:0]       dec_code;
  logic             dec_shamt;
  logic             dec_illegal;
  logic             dec_is_md;
  logic [1:0]       dec_md_op;
  logic             accept;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hilo_nxt;

  alu_funct_decode u_dec (
    .alu_op    (alu_op),
    .funct     (funct),
    .code      (dec_code),
    .shamt_sel (dec_shamt),
    .illegal   (dec_illegal),
    .is_md     (dec_is_md),
    .md_op     (dec_md_op)
  );

  assign busy      = (state == ST_RUN);
  assign ready_out = ~busy;
  assign accept    = valid_in & ready_out & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hilo_we <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hilo_we <= hilo_nxt;
    end
  end

  // Flush wins over completion, so an aborted op never raises hilo_we.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hilo_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && dec_is_md) begin
          state_nxt = ST_RUN;
`ifdef ALU_CTRL_DIV_EN
          cnt_nxt = dec_md_op[1] ? CNT_W'(DIV_CYCLES - 1) : MUL_LOAD;
`else
          cnt_nxt = MUL_LOAD;
`endif
        end
      end
      default: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
          hilo_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ctrl   <= '0;
      ctrl_valid <= 1'b0;
      shamt_sel  <= 1'b0;
      illegal    <= 1'b0;
      md_start   <= 1'b0;
      md_op      <= 2'b00;
    end else begin
      ctrl_valid <= accept;
      md_start   <= accept & dec_is_md;
      if (accept) begin
        alu_ctrl  <= CTRL_W'(dec_code);
        shamt_sel <= dec_shamt;
        illegal   <= dec_illegal;
        md_op     <= dec_md_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: decode vector table plus scoreboarded
// ctrl_valid strobes and hand-written mul/div, flush and reset sequences.
module tb_alu_control_seq;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;
  localparam int NV    = 25;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [3:0] code;
    logic       shamt;
    logic       ill;
  } vec_t;

  typedef struct packed {
    logic [3:0] code;
    logic       shamt;
    logic       ill;
  } exp_t;

  logic       clk, reset, valid_in, flush;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       ready_out, ctrl_valid, shamt_sel, illegal, md_start, busy, hilo_we;
  logic [3:0] alu_ctrl;
  logic [1:0] md_op;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[NV];

  alu_control_seq #(.CTRL_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .alu_op     (alu_op),
    .funct      (funct),
    .flush      (flush),
    .ready_out  (ready_out),
    .alu_ctrl   (alu_ctrl),
    .ctrl_valid (ctrl_valid),
    .shamt_sel  (shamt_sel),
    .illegal    (illegal),
    .md_start   (md_start),
    .md_op      (md_op),
    .busy       (busy),
    .hilo_we    (hilo_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one request for the coming edge and record the strobe it should produce.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    valid_in = 1'b1;
    alu_op   = v.alu_op;
    funct    = v.funct;
    e.code   = v.code;
    e.shamt  = v.shamt;
    e.ill    = v.ill;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ctrl_valid strobe must match the oldest expected decode result.
  always @(negedge clk) begin
    if (ctrl_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL ctrl_valid_unexpected: actual=1 required=0 at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_alu_ctrl", 32'(alu_ctrl), 32'(mon_e.code));
        checkOutput("sb_shamt_sel", 32'(shamt_sel), 32'(mon_e.shamt));
        checkOutput("sb_illegal", 32'(illegal), 32'(mon_e.ill));
      end
    end
  end

  // Start a mul/div op now; optionally flush in cycle flushAt, optionally issue ADD on completion.
  task automatic runMd(input logic [5:0] fn, input int n, input int flushAt, input bit nextAdd);
    logic expBusy, expHilo;
    applyStimulus('{2'b10, fn, 4'b0010, 1'b0, 1'b0});
    for (int c = 1; c <= n + 1; c++) begin
      tick();
      valid_in = 1'b0;
      flush    = 1'b0;
      if (flushAt != 0 && c == flushAt) flush = 1'b1;
      if (c == 2 && n >= 2) begin
        valid_in = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'b100000;
      end
      if (c == n + 1 && nextAdd && flushAt == 0)
        applyStimulus('{2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0});
      @(negedge clk);
      if (flushAt == 0) begin
        expBusy = (c <= n);
        expHilo = (c == n + 1);
      end else begin
        expBusy = (c <= flushAt);
        expHilo = 1'b0;
      end
      checkOutput("md_start", 32'(md_start), 32'(c == 1));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("ready_out", 32'(ready_out), 32'(!expBusy));
      checkOutput("hilo_we", 32'(hilo_we), 32'(expHilo));
      if (c == 1) checkOutput("md_op", 32'(md_op), 32'(fn[1:0]));
    end
    tick();
    valid_in = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    checkOutput("md_tail_hilo_we", 32'(hilo_we), 32'd0);
    checkOutput("md_tail_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs = '{
      '{2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0},
      '{2'b11, 6'b001111, 4'b1101, 1'b0, 1'b0},
      '{2'b10, 6'b000011, 4'b1011, 1'b1, 1'b0},
      '{2'b10, 6'b111111, 4'b0010, 1'b0, 1'b1},
      '{2'b00, 6'b101010, 4'b0010, 1'b0, 1'b0},
      '{2'b01, 6'b000000, 4'b0110, 1'b0, 1'b0},
      '{2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0},
      '{2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0},
      '{2'b10, 6'b100110, 4'b0011, 1'b0, 1'b0},
      '{2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0},
      '{2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0},
      '{2'b10, 6'b101011, 4'b1000, 1'b0, 1'b0},
      '{2'b10, 6'b000000, 4'b1001, 1'b1, 1'b0},
      '{2'b10, 6'b000010, 4'b1010, 1'b1, 1'b0},
      '{2'b10, 6'b000001, 4'b0010, 1'b0, 1'b1},
      '{2'b10, 6'b100001, 4'b0010, 1'b0, 1'b0},
      '{2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0},
      '{2'b11, 6'b001000, 4'b0010, 1'b0, 1'b0},
      '{2'b11, 6'b001001, 4'b0010, 1'b0, 1'b0},
      '{2'b11, 6'b001010, 4'b0111, 1'b0, 1'b0},
      '{2'b11, 6'b001011, 4'b1000, 1'b0, 1'b0},
      '{2'b11, 6'b001100, 4'b0000, 1'b0, 1'b0},
      '{2'b11, 6'b001101, 4'b0001, 1'b0, 1'b0},
      '{2'b11, 6'b000000, 4'b0010, 1'b0, 1'b1},
      '{2'b11, 6'b001110, 4'b0011, 1'b0, 1'b0}
    };

    reset    = 1'b1;
    valid_in = 1'b0;
    flush    = 1'b0;
    alu_op   = 2'b00;
    funct    = 6'b000000;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("rst_shamt_sel", 32'(shamt_sel), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_md_start", 32'(md_start), 32'd0);
    checkOutput("rst_md_op", 32'(md_op), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_hilo_we", 32'(hilo_we), 32'd0);
    checkOutput("rst_ready_out", 32'(ready_out), 32'd1);
    tick();
    reset = 1'b0;

    $display("[TB] decode table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      tick();
    end
    valid_in = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("hold_ctrl_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("hold_alu_ctrl", 32'(alu_ctrl), 32'(vecs[NV-1].code));
    checkOutput("hold_busy", 32'(busy), 32'd0);

    $display("[TB] flush with valid_in in idle");
    tick();
    valid_in = 1'b1;
    flush    = 1'b1;
    alu_op   = 2'b10;
    funct    = 6'b100100;
    tick();
    valid_in = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    checkOutput("idle_flush_ctrl_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("idle_flush_alu_ctrl", 32'(alu_ctrl), 32'(vecs[NV-1].code));
    tick();

    $display("[TB] MULT with back-to-back ADD");
    runMd(6'b011000, MUL_N, 0, 1'b1);
    tick();
    $display("[TB] MULTU flushed in cycle 2");
    runMd(6'b011001, MUL_N, 2, 1'b0);
    tick();

`ifdef ALU_CTRL_DIV_EN
    $display("[TB] DIV full length");
    runMd(6'b011010, DIV_N, 0, 1'b1);
    tick();
    $display("[TB] DIVU flushed in cycle 3");
    runMd(6'b011011, DIV_N, 3, 1'b0);
    tick();
`else
    $display("[TB] DIVU without divider");
    applyStimulus('{2'b10, 6'b011011, 4'b0010, 1'b0, 1'b1});
    tick();
    valid_in = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("nodiv_busy", 32'(busy), 32'd0);
      checkOutput("nodiv_md_start", 32'(md_start), 32'd0);
      checkOutput("nodiv_hilo_we", 32'(hilo_we), 32'd0);
      tick();
    end
`endif

    $display("[TB] reset during MULT");
    applyStimulus('{2'b10, 6'b011000, 4'b0010, 1'b0, 1'b0});
    tick();
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("rstrun_md_start", 32'(md_start), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < MUL_N + 2; c++) begin
      @(negedge clk);
      checkOutput("rstrun_busy", 32'(busy), 32'd0);
      checkOutput("rstrun_hilo_we", 32'(hilo_we), 32'd0);
      checkOutput("rstrun_ready_out", 32'(ready_out), 32'd1);
      tick();
    end

    checkOutput("sb_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
